// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write arbiter.
// NREG is the register count; ZERO_REG is the hardwired-zero register that must never be written.
package rf_pkg;

    localparam int NREG     = 32;
    localparam int DEF_AW   = 5;
    localparam int DEF_DW   = 32;
    localparam int ZERO_REG = 0;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Requests are scanned starting at index ptr and wrap modulo NREQ; the result is a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx
);

    int            j;
    logic [PW-1:0] jp;

    // The scan runs from the farthest offset down to the nearest.
    // Whichever request is closest to ptr is written last and therefore wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        j       = 0;
        jp      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            jp = PW'(j);
            if (req[jp]) begin
                gnt     = '0;
                gnt[jp] = 1'b1;
                gnt_idx = jp;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter and clear sequencer for the 32x32 register file.
// It shares the single write port round-robin and can zero registers 1..NREG-1, one per cycle.
module regfile_wr_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata
);

    localparam int PW = $clog2(NREQ);

    state_t          state, state_n;
    logic [AW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   ptr, ptr_n;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            we_n, busy_n;
    logic [AW-1:0]   waddr_n;
    logic [DW-1:0]   wdata_n;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants are offered only in IDLE when no clear is pending. They are also suppressed while reset is asserted.
    assign req_ready = (rst_n && state == IDLE && !clear_req) ? gnt : '0;
    assign xfer      = |req_ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // cnt always equals the address that is presented on rf_waddr during the clear.
    // When the last register's write is registered, the FSM returns to IDLE.
    // clear_busy stays high for that final cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        we_n    = 1'b0;
        busy_n  = 1'b0;
        waddr_n = rf_waddr;
        wdata_n = rf_wdata;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n = CLEAR;
                    cnt_n   = AW'(ZERO_REG + 1);
                    we_n    = 1'b1;
                    busy_n  = 1'b1;
                    waddr_n = AW'(ZERO_REG + 1);
                    wdata_n = '0;
                end else if (xfer) begin
                    ptr_n = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
                    if (sel_addr != AW'(ZERO_REG)) begin
                        we_n    = 1'b1;
                        waddr_n = sel_addr;
                        wdata_n = sel_data;
                    end
                end
            end
            CLEAR: begin
                cnt_n   = cnt + 1'b1;
                we_n    = 1'b1;
                busy_n  = 1'b1;
                waddr_n = cnt + 1'b1;
                wdata_n = '0;
                if (cnt + 1'b1 == AW'(NREG - 1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            clear_busy <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            rf_we      <= we_n;
            rf_waddr   <= waddr_n;
            rf_wdata   <= wdata_n;
            clear_busy <= busy_n;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed testbench for regfile_wr_arbiter with hand-computed expectations.
// A simple register-file monitor captures every write that the DUT issues.
module tb_regfile_wr_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic              clear_req = 1'b0;
    logic              clear_busy;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;

    int vectors = 0;
    int miscompares = 0;

    bit [DW-1:0] rf_model [0:31];

    regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    always #5 clk = ~clk;

    // The register file deliberately records writes to register 0 too, so any such write is visible.
    always @(posedge clk) begin
        if (rf_we) rf_model[rf_waddr] <= rf_wdata;
    end

    task automatic test_reset;
        $display("[TB] test_reset");
        rst_n = 1'b0;
        req_valid = '1;
        @(negedge clk);
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata, clear_busy} !== 39'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", {rf_we, rf_waddr, rf_wdata, clear_busy});
        end
        vectors++;
        if (req_ready !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 000", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write;
        $display("[TB] test_single_write");
        @(negedge clk);
        req_valid = 3'b010;
        req_addr[1*AW +: AW] = 5'd5;
        req_data[1*DW +: DW] = 32'hDEADBEEF;
        #1;
        vectors++;
        if (req_ready !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL single_ready: got %b expected 010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            miscompares++;
            $display("[TB] FAIL single_write: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd5, 32'hDEADBEEF});
        end
        @(negedge clk);
        vectors++;
        if (rf_model[5] !== 32'hDEADBEEF || rf_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_readback: got reg5=%h we=%b expected deadbeef/0", rf_model[5], rf_we);
        end
        req_valid = 3'b100;
        req_addr[2*AW +: AW] = 5'd7;
        req_data[2*DW +: DW] = 32'h12345678;
        #1;
        vectors++;
        if (req_ready !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL req2_ready: got %b expected 100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h12345678}) begin
            miscompares++;
            $display("[TB] FAIL req2_write: got %h expected %h", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd7, 32'h12345678});
        end
    endtask

    task automatic test_round_robin;
        int prev;
        logic [NREQ-1:0] exp_rdy;
        $display("[TB] test_round_robin");
        prev = 0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = 5'(i + 1);
            req_data[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        end
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(negedge clk);
                vectors++;
                if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(prev + 1), 32'hA000_0000 + 32'(prev)}) begin
                    miscompares++;
                    $display("[TB] FAIL rr_write%0d: got %h", k, {rf_we, rf_waddr, rf_wdata});
                end
            end
            #1;
            exp_rdy = 3'(1 << (k % 3));
            vectors++;
            if (req_ready !== exp_rdy) begin
                miscompares++;
                $display("[TB] FAIL rr_ready%0d: got %b expected %b", k, req_ready, exp_rdy);
            end
            prev = k % 3;
        end
        @(negedge clk);
        req_valid = '0;
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'hA000_0002}) begin
            miscompares++;
            $display("[TB] FAIL rr_last_write: got %h", {rf_we, rf_waddr, rf_wdata});
        end
        @(negedge clk);
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 32'hA000_0002}) begin
            miscompares++;
            $display("[TB] FAIL rr_idle_hold: got %h", {rf_we, rf_waddr, rf_wdata});
        end
    endtask

    task automatic test_zero_addr;
        $display("[TB] test_zero_addr");
        req_valid = 3'b001;
        req_addr[0 +: AW] = 5'd0;
        req_data[0 +: DW] = 32'hFFFFFFFF;
        #1;
        vectors++;
        if (req_ready !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL zero_ready: got %b expected 001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 32'hA000_0002}) begin
            miscompares++;
            $display("[TB] FAIL zero_no_write: got %h", {rf_we, rf_waddr, rf_wdata});
        end
        @(negedge clk);
        vectors++;
        if (rf_model[0] !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL zero_reg0: got %h expected 0", rf_model[0]);
        end
        req_valid = 3'b011;
        req_addr[0 +: AW] = 5'd4;
        req_data[0 +: DW] = 32'h44;
        #1;
        vectors++;
        if (req_ready !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL zero_ptr_adv: got %b expected 010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 32'hA000_0001}) begin
            miscompares++;
            $display("[TB] FAIL zero_next_write: got %h", {rf_we, rf_waddr, rf_wdata});
        end
    endtask

    task automatic test_preload(input logic [DW-1:0] base);
        int bad;
        $display("[TB] test_preload base=%h", base);
        bad = 0;
        for (int i = 1; i < 32; i++) begin
            req_valid = 3'b001;
            req_addr[0 +: AW] = 5'(i);
            req_data[0 +: DW] = base | 32'(i);
            #1;
            vectors++;
            if (req_ready !== 3'b001) begin
                miscompares++;
                $display("[TB] FAIL preload_ready%0d: got %b expected 001", i, req_ready);
            end
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
        for (int i = 1; i < 32; i++) if (rf_model[i] !== (base | 32'(i))) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL preload_contents: got %0d wrong registers expected 0", bad);
        end
    endtask

    task automatic test_clear;
        int bad;
        logic [NREQ-1:0] exp_rdy;
        $display("[TB] test_clear");
        bad = 0;
        clear_req = 1'b1;
        req_valid = 3'b100;
        req_addr[2*AW +: AW] = 5'd9;
        req_data[2*DW +: DW] = 32'hCAFEF00D;
        #1;
        vectors++;
        if (req_ready !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL clear_wins: got %b expected 000", req_ready);
        end
        for (int c = 1; c < 32; c++) begin
            @(negedge clk);
            clear_req = (c == 5);
            vectors++;
            if ({rf_we, rf_waddr, rf_wdata, clear_busy} !== {1'b1, 5'(c), 32'h0, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL clear_step%0d: got %h expected %h", c, {rf_we, rf_waddr, rf_wdata, clear_busy}, {1'b1, 5'(c), 32'h0, 1'b1});
            end
            #1;
            exp_rdy = (c == 31) ? 3'b100 : 3'b000;
            vectors++;
            if (req_ready !== exp_rdy) begin
                miscompares++;
                $display("[TB] FAIL clear_ready%0d: got %b expected %b", c, req_ready, exp_rdy);
            end
        end
        @(negedge clk);
        req_valid = '0;
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata, clear_busy} !== {1'b1, 5'd9, 32'hCAFEF00D, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL clear_post_write: got %h", {rf_we, rf_waddr, rf_wdata, clear_busy});
        end
        @(negedge clk);
        for (int i = 1; i < 32; i++) if (rf_model[i] !== ((i == 9) ? 32'hCAFEF00D : 32'h0)) bad++;
        vectors++;
        if (bad != 0 || rf_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear_contents: got %0d wrong registers we=%b expected 0/0", bad, rf_we);
        end
    endtask

    task automatic test_reset_mid_clear;
        int bad;
        $display("[TB] test_reset_mid_clear");
        bad = 0;
        clear_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            clear_req = 1'b0;
            vectors++;
            if ({rf_we, rf_waddr} !== {1'b1, 5'(c)}) begin
                miscompares++;
                $display("[TB] FAIL abort_step%0d: got %h", c, {rf_we, rf_waddr});
            end
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rf_we, rf_waddr, rf_wdata, clear_busy, req_ready} !== 42'd0) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs: got %h expected 0", {rf_we, rf_waddr, rf_wdata, clear_busy, req_ready});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (rf_we !== 1'b0 || clear_busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL abort_quiet%0d: got we=%b busy=%b expected 0/0", k, rf_we, clear_busy);
            end
        end
        for (int i = 1; i < 32; i++) if (rf_model[i] !== ((i < 10) ? 32'h0 : (32'h7700_0000 | 32'(i)))) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL abort_contents: got %0d wrong registers expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_zero_addr();
        test_preload(32'h5A00_0000);
        test_clear();
        test_preload(32'h7700_0000);
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
